// File: rtl/seq_det_pkg.sv
// Shared defaults and helpers for the serial pattern detector family.
// Pure constants and functions, no logic of its own.
package seq_det_pkg;

    localparam logic [31:0] DEF_PATTERN = 32'b10110;
    localparam int          DEF_LEN     = 5;
    localparam bit          DEF_OVERLAP = 1'b1;

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Zero means "one bit"; anything beyond the hardware limit saturates.
    function automatic int clamp_len(input int len, input int max_len);
        if (len < 1)
            return 1;
        if (len > max_len)
            return max_len;
        return len;
    endfunction

endpackage

// File: rtl/seq_pattern_detector_if.sv
// Config, serial-bit and status bundle of the pattern detector.
// master = stimulus/config side, slave = detector.
interface seq_pattern_detector_if
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = len_w(MAX_LEN);

    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               x_valid;
    logic               x;
    logic               clr_count;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic               partial;

    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_overlap, x_valid, x, clr_count,
        input  match, match_count, partial
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, x_valid, x, clr_count,
        output match, match_count, partial
    );

endinterface

// File: rtl/seq_pattern_detector_sat_counter.sv
// Saturating event counter; clear wins over hold but a same-cycle event counts as 1.
// Latency: count updates on the edge that samples inc/clr; never stalls.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? CNT_W'(1) : '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial pattern detector with overlap mode and match counter.
// Latency: match registered one cycle after the completing bit; no backpressure, x_valid qualifies.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_PATTERN),
    parameter int                 RST_LEN     = DEF_LEN,
    parameter bit                 RST_OVERLAP = DEF_OVERLAP
) (
    input  logic                  clk,
    input  logic                  reset,
    seq_pattern_detector_if.slave bus
);

    localparam int               LEN_W     = len_w(MAX_LEN);
    localparam logic [LEN_W-1:0] RST_LEN_C = LEN_W'(clamp_len(RST_LEN, MAX_LEN));
    localparam logic [LEN_W:0]   ONE_X     = (LEN_W+1)'(1);

    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;

    // The newest bit is taken straight from x, so MAX_LEN-1 stored bits cover MAX_LEN.
    logic [MAX_LEN-2:0] hist_q;
    logic [MAX_LEN-1:0] hist_n;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill_q;
    logic [LEN_W-1:0]   fill_n;
    logic               qual;
    logic               hit;
    logic               match_q;
    logic [CNT_W-1:0]   count;

    always_comb begin
        qual   = bus.x_valid && !bus.cfg_load;
        hist_n = {hist_q, bus.x};
        mask   = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
        hit = qual
            && (({1'b0, fill_q} + ONE_X) >= {1'b0, len_q})
            && (((hist_n ^ pat_q) & mask) == '0);
        if (hit && !ovl_q) begin
            fill_n = '0;
        end else if (fill_q >= len_q) begin
            fill_n = len_q;
        end else begin
            fill_n = fill_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q   <= RST_PATTERN;
            len_q   <= RST_LEN_C;
            ovl_q   <= RST_OVERLAP;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else if (bus.cfg_load) begin
            pat_q   <= bus.cfg_pattern;
            len_q   <= LEN_W'(clamp_len(int'(bus.cfg_len), MAX_LEN));
            ovl_q   <= bus.cfg_overlap;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else begin
            // match is a pulse: idle cycles drop it while history and fill hold.
            match_q <= hit;
            if (bus.x_valid) begin
                hist_q <= hist_n[MAX_LEN-2:0];
                fill_q <= fill_n;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (hit),
        .clr   (bus.clr_count),
        .count (count)
    );

    assign bus.match       = match_q;
    assign bus.match_count = count;
    assign bus.partial     = (fill_q != '0) && !match_q;

endmodule

// File: doc/seq_pattern_detector.md
# seq_pattern_detector

Parametrised, runtime-programmable serial bit-pattern detector. It succeeds the fixed 5-bit overlapping "10110" detector and adds:
- pattern length up to MAX_LEN with a runtime pattern;
- an overlapping or non-overlapping mode;
- an input qualifier, a registered match pulse and a saturating match counter.

It sits on a serial bit stream (one bit per qualified clock) and feeds status or interrupt logic.

## Interface
- MAX_LEN, 8: longest supported pattern in bits; legal range 2..32.
- CNT_W, 8: match counter width.
- RST_PATTERN, 'b10110: pattern loaded at reset, right-aligned.
- RST_LEN, 5: pattern length loaded at reset; must be ≤ MAX_LEN.
- RST_OVERLAP, 1: mode loaded at reset (1 = overlapping).
- LEN_W is derived as $clog2(MAX_LEN+1); it is not user-settable.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- cfg_load  in  1  one-cycle strobe; samples cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- x_valid  in  1  qualifies x; unqualified cycles leave all state unchanged.
- x  in  1  serial data bit.
- clr_count  in  1  clears match_count.
- match  out  1  registered one-cycle pulse when a pattern completes.
- match_count  out  CNT_W  saturating count of matches.
- partial  out  1  high while fill > 0 and no match is flagged this cycle (debug/status).

## Operation
- Active config registers: pat_q, len_q, ovl_q.
  - Reset values: RST_PATTERN, RST_LEN, RST_OVERLAP.
  - cfg_len = 0 is stored as 1; cfg_len > MAX_LEN is stored as MAX_LEN.
- Internal state:
  - hist: MAX_LEN-bit shift history; on a qualified bit, hist_n = {hist[MAX_LEN-2:0], x}, so the newest bit is at [0].
  - fill: count of qualified bits since the last restart; saturates at len_q.
- Match condition, evaluated on a qualified bit: (fill+1 ≥ len_q) and hist_n[len_q-1:0] == pat_q[len_q-1:0]. Bits above len_q are ignored.
- On a match:
  - ovl_q = 1: fill saturates and detection continues, so a suffix can start the next match.
  - ovl_q = 0: fill ← 0, so no bit of a matched pattern is reused.
- cfg_load:
  - updates the config registers;
  - clears hist, fill and match;
  - does not clear match_count.
  - The x bit in the same cycle is discarded; cfg_load has priority over x_valid.
- Counter:
  - increments by 1 per match and holds at 2^CNT_W-1.
  - When clr_count and a match occur in the same cycle, the result is 1.
  - clr_count alone gives 0.
- Reset values: match = 0, match_count = 0, partial = 0, hist = 0, fill = 0.

## Timing
- Latency: match goes high in the cycle after the clock edge that samples the completing bit (x_valid = 1). It stays high for exactly one cycle unless the next qualified bit also completes a match.
  - Example: len 1, overlap, pattern 1, x = 1 on consecutive cycles gives match high continuously.
- match_count updates on the same edge that raises match.
- A cfg_load takes effect for the bit on the following qualified cycle.
- Asserting reset mid-pattern immediately clears all outputs and state and restores the RST_* config. Detection restarts from an empty history after release.
- No combinational path from inputs to outputs.

## Structure
- Package seq_det_pkg holds:
  - the RST_PATTERN, RST_LEN and RST_OVERLAP defaults;
  - a len_w(max_len) function;
  - a clamp_len function.
- One sub-module: sat_counter (CNT_W parameter; inc, clr, count with the clr+inc = 1 rule). It is reused by other status blocks.
- Top level holds the config registers, hist, fill, compare/mask logic and the match register.

## Test plan
- Reset defaults, overlap mode, x = 1,0,1,1,0,1,1,0 all valid: match pulses after bits 5 and 8; match_count = 2.
- Load pattern 10110 with len 5 and overlap 0, same stream: a single match after bit 5; match_count = 1; partial = 1 after bits 6–8.
- Load len 3, pattern 101, overlap 1, stream 1,0,1,0,1 with x_valid low on alternate cycles: matches after the 3rd and 5th valid bits only; idle cycles change nothing.
- CNT_W = 2, len 1, pattern 1, overlap 1, five 1s: match_count goes 1,2,3,3,3. Then clr_count together with a match gives 1.
- Assert reset mid-pattern (after 1,0,1,1 of 10110), then release and send 0: no match. The full pattern 10110 afterwards gives a match.
- cfg_load with cfg_len = 0 and with cfg_len = MAX_LEN+3: stored lengths are 1 and MAX_LEN respectively. The x bit sent in the load cycle is ignored.
